// File: rtl/sar_search_ctrl_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
// Holds the FSM state encoding, the default width and the flag sanity check.
package sar_search_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // A healthy comparator asserts exactly one of gt/eq/lt.
    function automatic logic flags_one_hot(input logic gt, input logic eq, input logic lt);
        return ({gt, eq, lt} == 3'b100) || ({gt, eq, lt} == 3'b010) || ({gt, eq, lt} == 3'b001);
    endfunction

endpackage

// File: rtl/sar_search_ctrl_if.sv
// Comparator-loop bundle: control request, comparator flags and search outputs.
// master = search controller, slave = comparator/requester side.
interface sar_search_ctrl_if
    import sar_search_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             cmp_lt;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;

    modport master (
        input  start, cmp_gt, cmp_eq, cmp_lt,
        output guess, busy, done, result, found, err
    );

    modport slave (
        output start, cmp_gt, cmp_eq, cmp_lt,
        input  guess, busy, done, result, found, err
    );

endinterface

// File: rtl/sar_search_ctrl.sv
// MSB-first successive-approximation search driving an external magnitude comparator.
// One trial per cycle; exits early on equality, otherwise confirms the final value in CHECK.
module sar_search_ctrl
    import sar_search_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    sar_search_ctrl_if.master   bus
);

    localparam int               IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB    = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] FIRST_TRY  = WIDTH'(1) << (WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             found_q, found_d;
    logic             err_q, err_d;

    logic             flags_ok;
    logic [WIDTH-1:0] trial_kept;

    assign flags_ok = flags_one_hot(bus.cmp_gt, bus.cmp_eq, bus.cmp_lt);

    // Current trial bit survives only if the guess was not above the target.
    assign trial_kept = bus.cmp_gt ? (guess_q & ~(WIDTH'(1) << idx_q)) : guess_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            guess_q  <= '0;
            result_q <= '0;
            idx_q    <= IDX_MSB;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        result_d = result_q;
        idx_d    = idx_q;
        found_d  = found_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    guess_d = FIRST_TRY;
                    idx_d   = IDX_MSB;
                    found_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_PROBE;
                end
            end

            ST_PROBE: begin
                if (!flags_ok) begin
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = guess_q;
                    state_d  = ST_DONE;
                end else if (bus.cmp_eq) begin
                    result_d = guess_q;
                    found_d  = 1'b1;
                    state_d  = ST_DONE;
                end else if (idx_q == '0) begin
                    guess_d = trial_kept;
                    state_d = ST_CHECK;
                end else begin
                    guess_d = trial_kept | (WIDTH'(1) << (idx_q - 1'b1));
                    idx_d   = idx_q - 1'b1;
                end
            end

            ST_CHECK: begin
                found_d  = bus.cmp_eq;
                err_d    = !flags_ok;
                result_d = guess_q;
                state_d  = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.guess  = guess_q;
    assign bus.result = result_q;
    assign bus.found  = found_q;
    assign bus.err    = err_q;
    assign bus.busy   = (state_q == ST_PROBE) || (state_q == ST_CHECK);
    assign bus.done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Closed-loop bench: a comparator model answers the controller's guesses against a target.
// Expected guesses and final results are queued at stimulus time and popped as the DUT produces them.
module tb_sar_search_ctrl;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] result;
        logic         found;
        logic         err;
        int           cycle;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sar_search_ctrl_if #(.WIDTH(W)) bus_if ();

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.master)
    );

    logic [W-1:0] target = '0;
    logic         bad_flags = 1'b0;

    // Magnitude comparator model, A = guess, B = target; bad_flags forces gt and lt together.
    assign bus_if.cmp_gt = bad_flags | (bus_if.guess > target);
    assign bus_if.cmp_lt = bad_flags | (bus_if.guess < target);
    assign bus_if.cmp_eq = !bad_flags && (bus_if.guess == target);

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [W-1:0] guess_sb[$];
    exp_t         res_sb[$];

    // Reference: plain MSB-first binary search over an accumulator.
    task automatic build_expect(input logic [W-1:0] tgt, input int fault_probe);
        logic [W-1:0] acc;
        logic [W-1:0] one;
        logic [W-1:0] trial;
        exp_t         e;
        bit           fin;
        int           k;
        acc = '0;
        one = 1;
        fin = 0;
        k   = 0;
        e.result = '0; e.found = 1'b0; e.err = 1'b0; e.cycle = 0;
        for (int b = W - 1; b >= 0 && !fin; b--) begin
            k++;
            trial = acc | (one << b);
            guess_sb.push_back(trial);
            if (k == fault_probe) begin
                e.result = trial; e.found = 1'b0; e.err = 1'b1; e.cycle = k + 1; fin = 1;
            end else if (trial == tgt) begin
                e.result = trial; e.found = 1'b1; e.err = 1'b0; e.cycle = k + 1; fin = 1;
            end else if (trial < tgt) begin
                acc = trial;
            end
        end
        if (!fin) begin
            guess_sb.push_back(acc);
            e.result = acc; e.found = (acc == tgt); e.err = 1'b0; e.cycle = W + 2;
        end
        res_sb.push_back(e);
    endtask

    // Runs one search; optionally corrupts flags at a probe, re-pulses start mid-search,
    // or pulses start in the DONE cycle.
    task automatic do_search(input logic [W-1:0] tgt, input int fault_probe,
                             input int restart_cycle, input bit start_in_done, input string tag);
        int           cycle;
        bit           seen_done;
        logic [W-1:0] exp_g;
        exp_t         e;
        logic [W-1:0] held;
        target = tgt;
        build_expect(tgt, fault_probe);
        @(negedge clk);
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        cycle = 1;
        seen_done = 0;
        held = '0;
        while (!seen_done && cycle <= 20) begin
            bus_if.start = (cycle == restart_cycle);
            bad_flags    = (cycle == fault_probe);
            if (bus_if.busy === 1'b1) begin
                total_cnt++;
                if (guess_sb.size() == 0) begin
                    $display("FAIL %s guess: got %0d at cycle %0d, required no more trials", tag, bus_if.guess, cycle);
                end else begin
                    exp_g = guess_sb.pop_front();
                    if (bus_if.guess !== exp_g)
                        $display("FAIL %s guess c%0d: got %0d required %0d", tag, cycle, bus_if.guess, exp_g);
                    else
                        pass_cnt++;
                end
            end else if (bus_if.done === 1'b1) begin
                seen_done = 1;
                e = res_sb.pop_front();
                total_cnt++;
                if (cycle !== e.cycle) $display("FAIL %s done_cycle: got %0d required %0d", tag, cycle, e.cycle);
                else pass_cnt++;
                total_cnt++;
                if (bus_if.result !== e.result) $display("FAIL %s result: got %0d required %0d", tag, bus_if.result, e.result);
                else pass_cnt++;
                total_cnt++;
                if (bus_if.found !== e.found) $display("FAIL %s found: got %0b required %0b", tag, bus_if.found, e.found);
                else pass_cnt++;
                total_cnt++;
                if (bus_if.err !== e.err) $display("FAIL %s err: got %0b required %0b", tag, bus_if.err, e.err);
                else pass_cnt++;
                total_cnt++;
                if (guess_sb.size() != 0) $display("FAIL %s trials_left: got %0d required 0", tag, guess_sb.size());
                else pass_cnt++;
                held = e.result;
            end else begin
                total_cnt++;
                $display("FAIL %s busy c%0d: got busy=%0b done=%0b required one of them high", tag, cycle, bus_if.busy, bus_if.done);
            end
            if (!seen_done) begin
                @(posedge clk);
                #1;
                cycle++;
            end
        end
        bad_flags = 1'b0;
        bus_if.start = 1'b0;
        if (!seen_done) begin
            total_cnt++;
            $display("FAIL %s timeout: got no done within 20 cycles, required done", tag);
            guess_sb.delete();
            res_sb.delete();
        end else begin
            if (start_in_done) bus_if.start = 1'b1;
            @(posedge clk);
            #1;
            bus_if.start = 1'b0;
            total_cnt++;
            if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0)
                $display("FAIL %s idle_after_done: got busy=%0b done=%0b required 0/0", tag, bus_if.busy, bus_if.done);
            else pass_cnt++;
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus_if.busy !== 1'b0 || bus_if.result !== held)
                $display("FAIL %s hold: got busy=%0b result=%0d required 0/%0d", tag, bus_if.busy, bus_if.result, held);
            else pass_cnt++;
            $display("search %s target=%0d result=%0d found=%0b err=%0b done_cycle=%0d",
                     tag, tgt, bus_if.result, bus_if.found, bus_if.err, cycle);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({bus_if.guess, bus_if.result, bus_if.found, bus_if.err, bus_if.busy, bus_if.done} !== '0)
            $display("FAIL reset_state: got guess=%0d result=%0d found=%0b err=%0b busy=%0b done=%0b required all 0",
                     bus_if.guess, bus_if.result, bus_if.found, bus_if.err, bus_if.busy, bus_if.done);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (bus_if.busy !== 1'b0) $display("FAIL idle_no_start: got busy=%0b required 0", bus_if.busy);
        else pass_cnt++;
        $display("reset released, outputs idle");
    endtask

    task automatic test_mid_reset();
        target = 4'd13;
        @(negedge clk);
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus_if.guess !== '0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0)
            $display("FAIL mid_reset: got guess=%0d busy=%0b done=%0b required 0/0/0", bus_if.guess, bus_if.busy, bus_if.done);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus_if.done !== 1'b0) $display("FAIL mid_reset_done: got done=%0b required 0", bus_if.done);
            else pass_cnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset asserted during probe 3, search aborted");
    endtask

    initial begin
        bus_if.start = 1'b0;
        test_reset();
        do_search(4'd11, 0, 0, 1'b0, "target11");
        do_search(4'd8,  0, 0, 1'b0, "target8");
        do_search(4'd0,  0, 0, 1'b0, "target0");
        do_search(4'd15, 0, 0, 1'b0, "target15");
        do_search(4'd13, 2, 0, 1'b0, "fault_probe2");
        do_search(4'd5,  0, 2, 1'b1, "restart_busy");
        test_mid_reset();
        do_search(4'd6,  0, 0, 1'b0, "after_reset");
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] t;
            t = W'($urandom_range(0, 15));
            do_search(t, 0, 0, 1'b0, "random");
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation search controller.
- Drives a trial value (guess) into an external magnitude comparator whose other operand is an unknown target. Reads back the one-hot gt/eq/lt flags and converges on the target MSB-first.
- It is the consumer/driver end of the comparator interface: the comparator turns operands into flags; this block turns flags into an operand.
- Used by lab benches and datapaths that must recover a value visible only through comparison.

Parameters:
- WIDTH, 4, bit width of guess/result; search range 0 .. 2^WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a search; sampled on rising clk edge; ignored unless in IDLE.
- cmp_gt  input  1  comparator flag: guess > target. Combinational from guess, same cycle.
- cmp_eq  input  1  comparator flag: guess == target.
- cmp_lt  input  1  comparator flag: guess < target.
- guess  output  WIDTH  trial value driven to comparator operand A; registered.
- busy  output  1  high in PROBE and CHECK states.
- done  output  1  one-cycle pulse when search ends.
- result  output  WIDTH  final value; held from done until next accepted start.
- found  output  1  result confirmed equal to target; valid with/after done.
- err  output  1  flags were not one-hot at some evaluated cycle; valid with/after done.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, guess=0, result=0, found=0, err=0, done=0, busy=0, bit index=WIDTH-1. Reset mid-search aborts immediately; no done pulse.
- State IDLE:
  - On start: guess <= 1<<(WIDTH-1); bit index <= WIDTH-1; found, err <= 0; go to PROBE.
  - result is held until the next start is accepted.
- State PROBE, one trial per cycle. Flags are evaluated against the current registered guess and acted on at the clock edge, in this priority:
  - Flags not exactly one-hot: err<=1, found<=0, result<=guess, go to DONE.
  - cmp_eq: result<=guess, found<=1, go to DONE (early exit).
  - Otherwise: next = guess with bit[idx] cleared if cmp_gt, else unchanged (cmp_lt).
    - idx==0: guess<=next, go to CHECK.
    - idx>0: guess<=next | (1<<(idx-1)), idx<=idx-1.
- State CHECK, final confirmation cycle for the all-cleared-path case (e.g. target 0):
  - cmp_eq: found<=1.
  - Otherwise: found<=0.
  - Non-one-hot flags: err<=1.
  - In all cases result<=guess; go to DONE.
- State DONE: done=1 for exactly this cycle, busy=0, then IDLE. A start seen in DONE is ignored.
- Latency: start sampled at edge 0.
  - Probe k (k=1..WIDTH) is presented in cycle k.
  - Early eq at probe k gives done in cycle k+1.
  - The no-early-eq path gives CHECK in cycle WIDTH+1 and done in cycle WIDTH+2.
  - Worst case: 6 cycles for WIDTH=4.
- start while busy: ignored; no restart and no queueing.
- guess only changes at clock edges, so the comparator sees a stable operand for a full cycle.
- found=0 with err=0 occurs only if the target moves mid-search; behaviour is otherwise defined as above.

Decomposition:
- Shared package: state enum (IDLE, PROBE, CHECK, DONE), default WIDTH constant, and a one-hot-check function for the {gt,eq,lt} flag triple.
- No sub-module in RTL. The bench closes the loop with a magnitude comparator model (A=guess, B=target).

Test Plan:
- WIDTH=4, target=11, pulse start:
  - guess sequence 8, 12, 10, 11.
  - eq at probe 4; done in cycle 5 with result=11, found=1, err=0.
- target=8: eq on first probe (guess=8); done in cycle 2, result=8, found=1.
- target=0:
  - guesses 8, 4, 2, 1 all gt; CHECK presents 0 with eq.
  - done in cycle 6, result=0, found=1.
- target=15: guesses 8, 12, 14, 15; done in cycle 5, result=15, found=1.
- Fault injection: force cmp_gt=cmp_lt=1 during probe 2 -> done next cycle, err=1, found=0, result=12 (target 13 path).
- Control: start re-pulsed while busy -> ignored, sequence unchanged. rst_n low during probe 3 -> immediately guess=0, busy=0, no done. A later start runs a clean full search.
